// File: rtl/request_responder_pkg.sv
// rtl/request_responder_pkg.sv - shared types and constants for the request responder
package request_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int TIMER_W = 8;

  // Service time must fit the 8-bit timer and be at least one cycle.
  function automatic bit busy_cycles_ok(input int n);
    return (n >= 1) && (n <= 255);
  endfunction

endpackage

// File: rtl/request_responder_busy_timer.sv
// rtl/request_responder_busy_timer.sv - loadable down-counter with zero flag
module busy_timer
  import request_responder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  // Load takes priority; otherwise count down while enabled, stopping at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/request_responder.sv
// rtl/request_responder.sv - accepts request pulses, services them for a fixed time, acks
module request_responder
  import request_responder_pkg::*;
#(
  parameter int BUSY_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             request,
  input  logic             hold,
  input  logic             err_clr,
  output logic             ready,
  output logic             busy,
  output logic             ack,
  output logic [CNT_W-1:0] req_count,
  output logic             proto_err
);

  if (!busy_cycles_ok(BUSY_CYCLES)) begin : g_bad_busy_cycles
    $error("request_responder: BUSY_CYCLES must be in 1..255");
  end

  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  state_t state;
  logic   accept;
  logic   timer_load;
  logic   timer_en;
  logic   timer_zero;

  // ready is only ever 1 in IDLE, so this is the whole accept condition.
  assign accept     = request && ready;
  assign timer_load = (state == IDLE) && accept;
  assign timer_en   = (state == BUSY);

  busy_timer u_busy_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (TIMER_LOAD),
    .zero     (timer_zero)
  );

  // Service FSM with registered handshake outputs, counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      req_count <= '0;
      proto_err <= 1'b0;
    end else begin
      // A violation on the same edge as err_clr wins so it is never lost.
      if (request && !ready) begin
        proto_err <= 1'b1;
      end else if (err_clr) begin
        proto_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          ready <= !hold;
          if (accept) begin
            state <= BUSY;
            ready <= 1'b0;
            busy  <= 1'b1;
            if (req_count != CNT_MAX) begin
              req_count <= req_count + 1'b1;
            end
          end
        end
        BUSY: begin
          if (timer_zero) begin
            state <= ACK;
            ack   <= 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
          ready <= !hold;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
          ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_request_responder.sv
// tb/tb_request_responder.sv - directed vector bench for request_responder
module tb_request_responder;

  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        request = 1'b0;
  logic        hold = 1'b0;
  logic        err_clr = 1'b0;
  logic        ready, busy, ack, proto_err;
  logic [15:0] req_count;
  logic        sat_ready, sat_busy, sat_ack, sat_err;
  logic [1:0]  sat_count;

  int total = 0;
  int passed = 0;
  int ack_cnt = 0;
  int sat_ack_cnt = 0;

  request_responder #(.BUSY_CYCLES(BC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .request(request), .hold(hold), .err_clr(err_clr),
    .ready(ready), .busy(busy), .ack(ack), .req_count(req_count), .proto_err(proto_err)
  );

  request_responder #(.BUSY_CYCLES(BC), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .request(request), .hold(hold), .err_clr(err_clr),
    .ready(sat_ready), .busy(sat_busy), .ack(sat_ack), .req_count(sat_count), .proto_err(sat_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && ack) ack_cnt <= ack_cnt + 1;
    if (!rst && sat_ack) sat_ack_cnt <= sat_ack_cnt + 1;
  end

  typedef struct {
    logic req, hld, clr;
    logic e_ready, e_busy, e_ack, e_err;
    int   e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic addv(input logic rq, input logic hl, input logic cl,
                      input logic r, input logic b, input logic a, input logic e, input int c);
    vec_t v;
    v.req = rq; v.hld = hl; v.clr = cl;
    v.e_ready = r; v.e_busy = b; v.e_ack = a; v.e_err = e; v.e_cnt = c;
    vecs.push_back(v);
  endtask

  // One request pulse from a well-behaved requester; expects exactly one ack.
  task automatic txn(input string tag);
    int n = 0;
    int a;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, int'(ready), 1);
    a = ack_cnt;
    request = 1'b1;
    @(negedge clk);
    request = 1'b0;
    repeat (BC + 2) @(negedge clk);
    #1;
    chk({tag, "_ack"}, ack_cnt, a + 1);
  endtask

  initial begin
    int a;
    // accept, full service, ack, ready returns
    addv(0,0,0, 1,0,0,0, 0);
    addv(1,0,0, 0,1,0,0, 1);
    addv(0,0,0, 0,1,0,0, 1);
    addv(0,0,0, 0,1,0,0, 1);
    addv(0,0,0, 0,1,0,0, 1);
    addv(0,0,0, 0,1,1,0, 1);
    addv(0,0,0, 1,0,0,0, 1);
    // requests during BUSY and during ACK
    addv(1,0,0, 0,1,0,0, 2);
    addv(0,0,0, 0,1,0,0, 2);
    addv(1,0,0, 0,1,0,1, 2);
    addv(0,0,0, 0,1,0,1, 2);
    addv(0,0,0, 0,1,1,1, 2);
    addv(1,0,0, 1,0,0,1, 2);
    addv(0,0,1, 1,0,0,0, 2);
    // hold withholds ready; request under hold is an error; set beats clear
    addv(0,1,0, 0,0,0,0, 2);
    addv(1,1,0, 0,0,0,1, 2);
    addv(1,1,1, 0,0,0,1, 2);
    addv(0,0,1, 1,0,0,0, 2);
    // request held for three cycles
    addv(1,0,0, 0,1,0,0, 3);
    addv(1,0,0, 0,1,0,1, 3);
    addv(1,0,0, 0,1,0,1, 3);
    addv(0,0,0, 0,1,0,1, 3);
    addv(0,0,0, 0,1,1,1, 3);
    addv(0,0,0, 1,0,0,1, 3);
    addv(0,0,1, 1,0,0,0, 3);
    // hold rises in the same cycle as a request while ready is still 1
    addv(1,1,0, 0,1,0,0, 4);
    addv(0,1,0, 0,1,0,0, 4);
    addv(0,1,0, 0,1,0,0, 4);
    addv(0,1,0, 0,1,0,0, 4);
    addv(0,1,0, 0,1,1,0, 4);
    addv(0,1,0, 0,0,0,0, 4);
    addv(0,0,0, 1,0,0,0, 4);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_count", int'(req_count), 0);
    chk("rst_err", int'(proto_err), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      request = vecs[i].req;
      hold    = vecs[i].hld;
      err_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ready", i), int'(ready), int'(vecs[i].e_ready));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      chk($sformatf("v%0d_ack", i), int'(ack), int'(vecs[i].e_ack));
      chk($sformatf("v%0d_err", i), int'(proto_err), int'(vecs[i].e_err));
      chk($sformatf("v%0d_count", i), int'(req_count), vecs[i].e_cnt);
      chk($sformatf("v%0d_satcount", i), int'(sat_count), (vecs[i].e_cnt > 3) ? 3 : vecs[i].e_cnt);
    end
    @(negedge clk);
    request = 1'b0; hold = 1'b0; err_clr = 1'b0;

    // twenty back-to-back transactions from a requester model
    for (int t = 0; t < 20; t++) txn($sformatf("txn%0d", t));
    #1;
    chk("txn_count", int'(req_count), 24);
    chk("txn_acks", ack_cnt, 24);
    chk("txn_err", int'(proto_err), 0);
    chk("sat_count", int'(sat_count), 3);
    chk("sat_acks", sat_ack_cnt, 24);
    chk("sat_err", int'(sat_err), 0);
    chk("sat_idle", int'(sat_ready && !sat_busy), 1);

    // reset in the middle of BUSY abandons the service
    request = 1'b1;
    @(negedge clk);
    request = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ready", int'(ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ack", int'(ack), 0);
    chk("midrst_count", int'(req_count), 0);
    chk("midrst_err", int'(proto_err), 0);
    a = ack_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (BC + 4) @(negedge clk);
    #1;
    chk("midrst_noack", ack_cnt, a);
    chk("midrst_ready_back", int'(ready), 1);
    txn("post_rst");
    chk("post_rst_count", int'(req_count), 1);
    chk("post_rst_err", int'(proto_err), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/request_responder.md
Name: request_responder

Overview:
- Downstream partner of the pulse requester: drives `ready` and consumes the single-cycle `request` pulses it produces.
- Accepts one request at a time and stays busy for a fixed service time.
- Emits a completion `ack` and counts accepted requests.
- Flags any request that arrives while `ready` is low as a sticky protocol error.
- Optional `hold` input lets the environment withhold `ready`, for backpressure tests and SVA checks.

Parameters:
- BUSY_CYCLES, 4: number of cycles spent in BUSY after an accept; legal range 1..255.
- CNT_W, 16: width of the accepted-request counter.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- request  input  1  request pulse from the requester.
- hold  input  1  when 1, `ready` is held low while idle.
- err_clr  input  1  clears `proto_err`.
- ready  output  1  the block can accept a request this cycle.
- busy  output  1  a service is in progress (BUSY or ACK state).
- ack  output  1  one-cycle pulse when a service completes.
- req_count  output  CNT_W  count of accepted requests; saturates at all-ones.
- proto_err  output  1  sticky flag: a request was seen while `ready` was 0.

Behaviour:
- All outputs are registered.
- Reset (asynchronous assert, any cycle, including mid-service):
  - state = IDLE, timer = 0.
  - ready = 0, busy = 0, ack = 0, req_count = 0, proto_err = 0.
  - Any in-flight service is abandoned; no `ack` is produced for it.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - `ready` <= !hold each edge. After reset release, `ready` first rises after the first edge that samples hold = 0.
  - Accept = request && ready, sampled at an edge. On accept: state <= BUSY, timer <= BUSY_CYCLES-1, ready <= 0, busy <= 1, req_count++ (saturating).
  - request && !ready (including when `hold` is the cause): no accept, no count, proto_err <= 1.
- BUSY:
  - timer decrements each edge; ready stays 0.
  - On the edge where timer == 0: state <= ACK, ack <= 1.
  - BUSY therefore lasts exactly BUSY_CYCLES cycles.
  - Any request seen here sets proto_err and is otherwise ignored.
  - `hold` has no effect on the service in progress.
- ACK (one cycle):
  - ack <= 0, busy <= 0, state <= IDLE, ready <= !hold.
  - A request seen in ACK is a protocol error, because ready is still 0.
- Timing, for an accept at edge N with hold = 0:
  - busy is high in cycles N..N+BUSY_CYCLES.
  - ack is high only in the cycle after edge N+BUSY_CYCLES.
  - ready returns after edge N+BUSY_CYCLES+1.
  - Accept-to-ready turnaround: BUSY_CYCLES+1 edges.
- Multi-cycle request: if request is held high across an accept, the following cycle sees ready = 0, so proto_err is set. Only one accept is counted.
- proto_err: set has priority over err_clr when both occur on the same edge; otherwise err_clr clears it.
- req_count at all-ones: further accepts are still serviced and acked, but the count holds.
- hold asserted in IDLE: ready falls on the next edge. A request arriving in that same cycle (ready still 1) is accepted normally.

Decomposition:
- Package request_responder_pkg:
  - state_t enum {IDLE, BUSY, ACK}.
  - TIMER_W = 8.
  - Elaboration check for 1 <= BUSY_CYCLES <= 255.
- Sub-module busy_timer: loadable down-counter with load, load_val and a `zero` flag, instantiated once.

Test Plan:
- Reset, then hold = 0 → ready = 1 after the first edge. With BUSY_CYCLES = 4, a 1-cycle request → busy for 5 cycles, ack pulse 4 edges after accept, ready back after 5 edges, req_count = 1, proto_err = 0.
- Drive with the requester model for 20 transactions → req_count = 20, 20 ack pulses, proto_err stays 0.
- Request pulses in BUSY cycle 2 and in the ACK cycle → proto_err = 1, req_count unchanged. err_clr pulse → proto_err = 0. err_clr on the same edge as a violation → proto_err stays 1.
- hold = 1 in IDLE → ready = 0 next cycle; a request then gives proto_err = 1 and no BUSY. Release hold → ready = 1 next cycle and the next request is accepted.
- Request held high for 3 cycles → a single accept, req_count += 1, proto_err = 1.
- Assert rst in the middle of BUSY → all outputs 0 immediately, no ack. After release, normal operation resumes. Separately, CNT_W = 2 with 5 accepts → req_count saturates at 3 and all 5 are acked.
